cv32e40p_fault_injector: RTL
============================

# cv32e40p_fault_injector

Programmable single-event-upset injector for the triplicated execution units. It drives a one-hot bit-flip mask onto one replica's output slice ahead of the voters, then watches the voters' disagreement flag to decide whether the upset was detected. Detected and missed events are counted. The block sits beside a TMR wrapper: its mask is XORed into `result_o_tmr[i]` before voting, and the wrapper returns an OR of voter disagreements as `mismatch_i`.

## Interface
Parameters:
- `NUM_INSTANCES`, default 3: replica count; mask slices.
- `WIDTH`, default 32: bits per replica output.
- `TIMEOUT`, default 15: observe-window length in cycles after injection ends (1..15).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_valid_i` in 1: injection request valid.
- `cfg_ready_o` out 1: high only in IDLE.
- `cfg_replica_i` in 2: target replica index.
- `cfg_bit_i` in 5: target bit within the slice.
- `cfg_delay_i` in 16: cycles from handshake to first inject cycle, minus 1.
- `cfg_duration_i` in 8: inject cycles minus 1.
- `abort_i` in 1: cancel the run in progress.
- `clear_i` in 1: clear both counters.
- `mismatch_i` in 1: any voter disagreement this cycle.
- `inj_mask_o` out NUM_INSTANCES*WIDTH: registered flip mask; slice i is bits [i*WIDTH +: WIDTH].
- `busy_o` out 1: state != IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `detected_o` out 1: result of the run, valid with `done_o`.
- `err_o` out 1: replica index invalid, valid with `done_o`.
- `latency_o` out 4: cycles from first inject cycle to first mismatch, saturating at 15; valid with `done_o` when detected.
- `det_count_o` out 16: detected runs, saturating.
- `miss_count_o` out 16: missed runs, saturating.

## Operation
- States: IDLE, DELAY, INJECT, OBSERVE, REPORT.
- IDLE: on `cfg_valid_i && cfg_ready_o`, capture all cfg fields.
  - If `cfg_replica_i >= NUM_INSTANCES`, go to REPORT with `err_o=1`, `detected_o=0`. No counter update.
  - Otherwise load the delay counter with `cfg_delay_i` and go to DELAY.
- DELAY: if the counter is 0, go to INJECT; otherwise decrement.
- INJECT:
  - The mask bit `replica*WIDTH+bit` is 1; all other bits are 0.
  - Hold the mask for `cfg_duration_i+1` cycles.
  - `mismatch_i` in any inject cycle latches det and captures latency (first hit only).
  - On the last inject cycle: go to REPORT if det is set (including a mismatch in that same cycle); otherwise go to OBSERVE.
- OBSERVE: the mask is all-zero.
  - `mismatch_i` sets det and captures latency, then go to REPORT.
  - After TIMEOUT cycles with no mismatch, go to REPORT with det=0.
- REPORT: held for one cycle.
  - Assert `done_o`.
  - Increment `det_count_o` if det, or `miss_count_o` if not det; skip both if err.
  - Return to IDLE.
- Latency: the cycle counter starts at 0 on the first inject cycle and saturates at 15.
- `abort_i` in any non-IDLE state:
  - Next state is IDLE and the mask clears on the same edge.
  - No `done_o` and no counter change.
  - Abort wins over REPORT if both occur in the same cycle.
  - In IDLE, `abort_i` is ignored.
- `clear_i` zeroes both counters. It wins over a same-cycle REPORT increment.
- Counters hold at 16'hFFFF.

## Timing
- Reset values:
  - State IDLE, `cfg_ready_o=1`, `inj_mask_o=0`.
  - `busy_o`, `done_o`, `detected_o`, `err_o` all 0.
  - `latency_o=0`, both counters 0.
- The handshake cycle is cycle 0. The first inject cycle (mask visible) is cycle `cfg_delay_i+2`. Delay 0 gives the mask at cycle 2.
- `done_o` rises the cycle after the deciding event. `cfg_ready_o` returns the cycle after `done_o`.
- A new request is accepted no earlier than 1 cycle after `done_o`.
- Invalid replica: `done_o` at cycle 1.
- Reset mid-run: all outputs return to reset values on the next edge; counters clear.
- All outputs are registered. `mismatch_i` is sampled combinationally into the next-state logic.

## Configuration
- `CV32E40P_FI_COUNTERS_EN` defined: the counters and `clear_i` logic are present, as described above.
- `CV32E40P_FI_COUNTERS_EN` undefined:
  - `det_count_o` and `miss_count_o` are tied to 0, and `clear_i` is ignored.
  - `done_o`, `detected_o` and `latency_o` are unchanged.

## Structure
- `cv32e40p_pkg` holds:
  - `fi_state_e` (IDLE, DELAY, INJECT, OBSERVE, REPORT);
  - `FI_LAT_W=4`;
  - `FI_CNT_W=16`.
- One sub-module, `cv32e40p_sat_counter` (parameter W; ports inc, clr, count), instantiated twice for the counters.

## Test plan
- Replica 1, bit 5, delay 3, duration 0; `mismatch_i` driven the same cycle the mask is seen -> mask bit 37 high at cycle 5 only; `done_o` at cycle 6; `detected_o=1`, `latency_o=0`, `det_count_o=1`.
- Replica 2, bit 31, delay 0, duration 2; `mismatch_i` never asserted -> mask bit 95 high for cycles 2-4; `done_o` after 15 OBSERVE cycles; `detected_o=0`, `miss_count_o=1`.
- Replica 3 (invalid) -> `done_o` at cycle 1 with `err_o=1`; mask stays 0; counters unchanged.
- Delay 100, `abort_i` at cycle 50 -> IDLE at cycle 51; no `done_o`; mask never set; `cfg_ready_o=1` at cycle 51.
- Mismatch arrives 20 cycles into a long INJECT (duration 30) -> `latency_o=15` (saturated), `detected_o=1` at end of injection.
- Preload `det_count_o` to 16'hFFFF, run a detected injection -> holds 16'hFFFF; then `clear_i` in the REPORT cycle -> 0.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types and widths for the fault-injection slice.
package cv32e40p_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    INJECT,
    OBSERVE,
    REPORT
  } fi_state_e;

  localparam int unsigned FI_LAT_W = 4;
  localparam int unsigned FI_CNT_W = 16;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module cv32e40p_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, zero on clear or reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cv32e40p_fault_injector.sv
// Single-event-upset injector for the TMR execution units.
// Optional macro CV32E40P_FI_COUNTERS_EN enables the detected/missed counters
// and clear_i; without it both counters read zero.
module cv32e40p_fault_injector
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_INSTANCES = 3,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
  input  logic [1:0]                     cfg_replica_i,
  input  logic [4:0]                     cfg_bit_i,
  input  logic [15:0]                    cfg_delay_i,
  input  logic [7:0]                     cfg_duration_i,
  input  logic                           abort_i,
  input  logic                           clear_i,
  input  logic                           mismatch_i,
  output logic [NUM_INSTANCES*WIDTH-1:0] inj_mask_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           detected_o,
  output logic                           err_o,
  output logic [FI_LAT_W-1:0]            latency_o,
  output logic [FI_CNT_W-1:0]            det_count_o,
  output logic [FI_CNT_W-1:0]            miss_count_o
);

  localparam int unsigned MASK_W = NUM_INSTANCES * WIDTH;

  fi_state_e             state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            replica_q;
  logic [4:0]            bit_q;
  logic [7:0]            dur_q;
  logic                  det_q;
  logic [FI_LAT_W-1:0]   lat_q, lat_cap_q;
  logic                  handshake, replica_bad, det_now;
  logic [FI_LAT_W-1:0]   lat_now;
  logic [MASK_W-1:0]     mask_d;
  int unsigned           mask_idx;

  assign handshake   = (state_q == IDLE) && cfg_valid_i && cfg_ready_o;
  assign replica_bad = 32'(cfg_replica_i) >= NUM_INSTANCES;
  // A mismatch in the deciding cycle counts even though det_q has not latched it yet.
  assign det_now     = det_q | mismatch_i;
  assign lat_now     = det_q ? lat_cap_q : lat_q;
  assign mask_idx    = 32'(replica_q) * WIDTH + 32'(bit_q);

  // Next-state logic; one down-counter is shared by DELAY, INJECT and OBSERVE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          if (replica_bad) begin
            state_d = REPORT;
          end else begin
            state_d = DELAY;
            cnt_d   = cfg_delay_i;
          end
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          state_d = INJECT;
          cnt_d   = 16'(dur_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      INJECT: begin
        if (cnt_q == '0) begin
          if (det_now) begin
            state_d = REPORT;
          end else begin
            state_d = OBSERVE;
            cnt_d   = 16'(TIMEOUT - 1);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      OBSERVE: begin
        if (mismatch_i || (cnt_q == '0)) begin
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Mask is decoded from the next state so it is registered alongside it.
  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      mask_d[i] = (state_d == INJECT) && (i == mask_idx);
    end
  end

  // State, run bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      replica_q   <= '0;
      bit_q       <= '0;
      dur_q       <= '0;
      det_q       <= 1'b0;
      lat_q       <= '0;
      lat_cap_q   <= '0;
      inj_mask_o  <= '0;
      cfg_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      detected_o  <= 1'b0;
      err_o       <= 1'b0;
      latency_o   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inj_mask_o  <= mask_d;
      cfg_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      done_o      <= (state_d == REPORT);
      if (handshake) begin
        replica_q <= cfg_replica_i;
        bit_q     <= cfg_bit_i;
        dur_q     <= cfg_duration_i;
      end
      if ((state_q == DELAY) && (state_d == INJECT)) begin
        det_q <= 1'b0;
        lat_q <= '0;
      end else if ((state_q == INJECT) || (state_q == OBSERVE)) begin
        if (lat_q != '1) lat_q <= lat_q + FI_LAT_W'(1);
        if (mismatch_i && !det_q) begin
          det_q     <= 1'b1;
          lat_cap_q <= lat_q;
        end
      end
      if (state_d == REPORT) begin
        err_o      <= (state_q == IDLE);
        detected_o <= (state_q != IDLE) && det_now;
        latency_o  <= ((state_q != IDLE) && det_now) ? lat_now : '0;
      end
    end
  end

`ifdef CV32E40P_FI_COUNTERS_EN
  logic inc_det, inc_miss;

  // Counters step in the REPORT cycle unless the run errored or is aborted there.
  assign inc_det  = (state_q == REPORT) && !abort_i && !err_o &&  detected_o;
  assign inc_miss = (state_q == REPORT) && !abort_i && !err_o && !detected_o;

  cv32e40p_sat_counter #(.W(FI_CNT_W)) u_det_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_det),
    .clr   (clear_i),
    .count (det_count_o)
  );

  cv32e40p_sat_counter #(.W(FI_CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_miss),
    .clr   (clear_i),
    .count (miss_count_o)
  );
`else
  logic unused_clear;

  assign unused_clear = clear_i;
  assign det_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule
